// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw buttons in, one-hot press pulses and debounced levels out
interface button_conditioner_if;
  logic [4:0] btn_raw;
  logic       btn_left_p;
  logic       btn_right_p;
  logic       btn_up_p;
  logic       btn_down_p;
  logic       btn_mid_p;
  logic [4:0] btn_level;
  modport master (
    input  btn_raw,
    output btn_left_p, btn_right_p, btn_up_p, btn_down_p, btn_mid_p, btn_level
  );
  modport slave (
    output btn_raw,
    input  btn_left_p, btn_right_p, btn_up_p, btn_down_p, btn_mid_p, btn_level
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and one-hot press pulses for five buttons; BTN_AUTOREPEAT_EN adds up/down auto-repeat
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input logic clk,
  input logic rst,
  button_conditioner_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [4:0] sync1, sync2, level, acc, press, cand, sel, pulse;
  logic [CW-1:0] cnt [5];
  always_comb begin
    acc = '0;
    for (int k = 0; k < 5; k++) acc[k] = (sync2[k] != level[k]) && (cnt[k] == CMAX);
  end
  assign press = acc & sync2;
  // bit order doubles as priority: mid(4) > left(3) > right(2) > up(1) > down(0)
  assign sel = cand[4] ? 5'b10000 :
               cand[3] ? 5'b01000 :
               cand[2] ? 5'b00100 :
               cand[1] ? 5'b00010 :
               {4'b0, cand[0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      pulse <= '0;
      for (int k = 0; k < 5; k++) cnt[k] <= '0;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
      level <= level ^ acc;
      pulse <= sel;
      for (int k = 0; k < 5; k++) cnt[k] <= (sync2[k] == level[k] || acc[k]) ? '0 : cnt[k] + 1'b1;
    end
  end
`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);
  localparam logic [RW-1:0] RLAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RRELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RW-1:0] rcnt [2];
  logic [1:0] rfire;
  // reloading to DELAY-PERIOD reuses one compare for both the first and later repeats
  always_comb begin
    rfire = '0;
    for (int k = 0; k < 2; k++) rfire[k] = level[k] && !acc[k] && (rcnt[k] == RLAST);
  end
  assign cand = press | {3'b0, rfire[1], rfire[0] & ~level[1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int k = 0; k < 2; k++) rcnt[k] <= '0;
    else for (int k = 0; k < 2; k++) rcnt[k] <= !level[k] ? '0 : rfire[k] ? RRELOAD : rcnt[k] + 1'b1;
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign cand = press;
`endif
  assign bus.btn_mid_p   = pulse[4];
  assign bus.btn_left_p  = pulse[3];
  assign bus.btn_right_p = pulse[2];
  assign bus.btn_up_p    = pulse[1];
  assign bus.btn_down_p  = pulse[0];
  assign bus.btn_level   = level;
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Sits directly upstream of the digit-entry input controller. It conditions the five raw push-button inputs (left, right, up, down, mid):
- synchronises each into clk,
- debounces each,
- emits single-cycle, one-hot press pulses that drive the controller's navigation, edit and confirm inputs.

It also exports the debounced levels for LEDs and debug.

Parameters:
DEBOUNCE_CYCLES, 1000000, stable-sample count required before a level change is accepted (10 ms at 100 MHz); legal range >= 2
REPEAT_DELAY, 50000000, cycles from first press pulse to first auto-repeat pulse (used only with the optional feature)
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_raw  in  5  raw asynchronous buttons: [4]=mid, [3]=left, [2]=right, [1]=up, [0]=down
btn_left_p  out  1  one-cycle press pulse, left
btn_right_p  out  1  one-cycle press pulse, right
btn_up_p  out  1  one-cycle press pulse, up
btn_down_p  out  1  one-cycle press pulse, down
btn_mid_p  out  1  one-cycle press pulse, mid
btn_level  out  5  debounced level, same bit order as btn_raw

Behaviour:
- Reset (asynchronous, active-high; clock clk): clears all synchroniser flops, debounce counters, btn_level (5'b0), all *_p outputs (0) and any repeat state. Reset asserted mid-press aborts the press; no pulse is emitted.
- A button held across reset release is treated as a new press: pulse after the normal latency.
- Synchroniser: 2-FF per bit, sync1 then sync2. No logic between the two stages.
- Debounce, per bit:
  - counter cnt, width $clog2(DEBOUNCE_CYCLES).
  - If sync2 == btn_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_level <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the old level before acceptance restarts the count from 0.
- Pulse generation:
  - Candidate press = accepting a 0->1 change on that bit, in the same edge as btn_level updates. Falling-edge acceptance produces no pulse.
  - Latency: call edge 0 the edge where sync1 first captures 1. Then btn_level and the pulse go high at edge DEBOUNCE_CYCLES+1. The pulse is high for exactly one cycle.
- One-hot rule: at most one *_p high in any cycle.
  - Fixed priority: mid > left > right > up > down.
  - Lower-priority candidates in the same cycle are dropped, not deferred.
  - btn_level still updates for all bits.
- All outputs are registered; no combinational path from btn_raw to any output.
- A press shorter than DEBOUNCE_CYCLES stable samples produces no pulse and no btn_level change.
- Continuous holding produces no further pulses, except as defined under Optional Feature.

Optional Feature:
Macro: BTN_AUTOREPEAT_EN
- Defined:
  - up and down get auto-repeat. While btn_level for that bit stays 1, a repeat counter runs from the initial press pulse.
  - First repeat pulse: REPEAT_DELAY cycles after the initial pulse. Further pulses every REPEAT_PERIOD cycles.
  - Release (btn_level 0) clears the repeat counter immediately.
  - Repeat pulses obey the one-hot priority. A repeat pulse dropped by priority is lost, but the period timing continues unchanged.
  - Only one of up/down repeats at a time; if both are held, up repeats.
- Undefined: no repeat logic is synthesised; exactly one pulse per accepted press. REPEAT_* parameters are ignored.

Test Plan:
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
1. Reset then idle 20 cycles -> all *_p=0, btn_level=5'b00000.
2. Clean press of up (btn_raw=5'b00010), held 30 cycles from edge 0 -> btn_up_p=1 only in cycle after edge 5, btn_level[1]=1 from edge 5. Release -> btn_level[1]=0 after edge 5 of release; no pulse. Without macro, no other pulse.
3. Bounce on left: raw toggles 1,1,0,1,1,0 each cycle, then held -> no pulse during the bounce; exactly one btn_left_p after 4 stable samples plus 2 sync cycles.
4. Press left and down in the same cycle, both held -> btn_left_p one cycle; btn_down_p never fires; btn_level=5'b01001.
5. Hold right, assert rst for 1 cycle at cycle 3 of the debounce count, keep holding -> no pulse before reset; all outputs 0 during reset; one btn_right_p at edge 5 counted from the first post-reset sync1 capture.
6. With BTN_AUTOREPEAT_EN, hold down 60 cycles -> btn_down_p at edges t0, t0+20, t0+28, t0+36, t0+44, t0+52. Release -> no further pulses.
